// File: rtl/pipeline_front_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types and constants for the RV32I fetch/decode front end:
//            the decoded control bundle and the NOP / bubble encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Decoded control bundle carried from decode into execute.
  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       MemtoReg;
    logic       Branch;
    logic       Jump;
    logic       ALUSrc;
    logic [2:0] ALUControl;
    logic [1:0] ResultSrc;
  } ctrl_t;

  // A bubble must never write state or change control flow; all-zero does that.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/pipeline_front_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_front_regs_if
// Purpose  : Bundles the hazard controls, decode inputs and the IF/ID + ID/EX
//            register outputs of the pipeline front end.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_front_regs_if #(
  parameter int DATA_WIDTH = 32
);
  import pipeline_pkg::*;

  // Hazard unit / execute redirect
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;

  // Fetch / decode inputs
  logic [DATA_WIDTH-1:0] InstrF;
  ctrl_t                 CtrlD;
  logic [DATA_WIDTH-1:0] RD1D;
  logic [DATA_WIDTH-1:0] RD2D;
  logic [DATA_WIDTH-1:0] ImmExtD;

  // Registered front-end state
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  ctrl_t                 CtrlE;
  logic [DATA_WIDTH-1:0] RD1E;
  logic [DATA_WIDTH-1:0] RD2E;
  logic [DATA_WIDTH-1:0] ImmExtE;
  logic [DATA_WIDTH-1:0] PCE;
  logic [DATA_WIDTH-1:0] PCPlus4E;
  logic [4:0]            Rs1E;
  logic [4:0]            Rs2E;
  logic [4:0]            RdE;
  logic                  ValidE;
  logic [15:0]           BubbleCnt;

  // Surrounding pipeline side
  modport master (
    output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
    output InstrF, CtrlD, RD1D, RD2D, ImmExtD,
    input  PCF, InstrD, PCD, PCPlus4D, CtrlE, RD1E, RD2E, ImmExtE,
    input  PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE, BubbleCnt
  );

  // Front-end register block side
  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
    input  InstrF, CtrlD, RD1D, RD2D, ImmExtD,
    output PCF, InstrD, PCD, PCPlus4D, CtrlE, RD1E, RD2E, ImmExtE,
    output PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE, BubbleCnt
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_front_regs_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Purpose  : Generic pipeline register with synchronous reset, clear and
//            enable (reset > clear > enable), typed by parameter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg #(
  parameter type T       = logic,
  parameter T    RST_VAL = '0,
  parameter T    CLR_VAL = '0
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  input  wire logic i_clr,
  input  wire T     i_d,
  output T          o_q
);

  T r_q;

  // Clear beats enable so a flush lands even while the stage is stalled.
  always_ff @(posedge clk) begin
    if (rst)        r_q <= RST_VAL;
    else if (i_clr) r_q <= CLR_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_front_regs.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_front_regs
// Purpose  : PC register plus IF/ID and ID/EX pipeline registers of the
//            5-stage RV32I core, with stall/flush/redirect handling and a
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_front_regs
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
  input wire logic             clk,
  input wire logic             rst,
  pipeline_front_regs_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcPlus4;
    logic                  valid;
  } ifid_t;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  valid;
  } idex_t;

  localparam ifid_t c_ifidNop    = {NOP_INSTR, {(2*DATA_WIDTH+1){1'b0}}};
  localparam idex_t c_idexBubble = {CTRL_BUBBLE, {(5*DATA_WIDTH+16){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_four = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pcF;
  logic [15:0]           r_bubbleCnt;
  ifid_t                 w_ifidD;
  ifid_t                 w_ifidQ;
  idex_t                 w_idexD;
  idex_t                 w_idexQ;
  logic                  w_bubbleLoad;

  // PC: a redirect from execute wins even over StallF so a resolved branch is never dropped.
  always_ff @(posedge clk) begin
    if (rst)                r_pcF <= RESET_PC;
    else if (bus.PCSrcE)    r_pcF <= bus.PCTargetE;
    else if (!bus.StallF)   r_pcF <= r_pcF + c_four;
  end

  // IF/ID next value: the fetched word, tagged as a real instruction.
  always_comb begin
    w_ifidD         = c_ifidNop;
    w_ifidD.instr   = bus.InstrF;
    w_ifidD.pc      = r_pcF;
    w_ifidD.pcPlus4 = r_pcF + c_four;
    w_ifidD.valid   = 1'b1;
  end

  pipe_reg #(
    .T       (ifid_t),
    .RST_VAL (c_ifidNop),
    .CLR_VAL (c_ifidNop)
  ) u_ifid (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~bus.StallD),
    .i_clr (bus.FlushD),
    .i_d   (w_ifidD),
    .o_q   (w_ifidQ)
  );

  // ID/EX next value: decode fields plus register indices sliced from the instruction.
  always_comb begin
    w_idexD         = c_idexBubble;
    w_idexD.ctrl    = bus.CtrlD;
    w_idexD.rd1     = bus.RD1D;
    w_idexD.rd2     = bus.RD2D;
    w_idexD.imm     = bus.ImmExtD;
    w_idexD.pc      = w_ifidQ.pc;
    w_idexD.pcPlus4 = w_ifidQ.pcPlus4;
    w_idexD.rs1     = w_ifidQ.instr[19:15];
    w_idexD.rs2     = w_ifidQ.instr[24:20];
    w_idexD.rd      = w_ifidQ.instr[11:7];
    w_idexD.valid   = w_ifidQ.valid;
  end

  // ID/EX never stalls; a load-use hold is built from StallF+StallD+FlushE upstream.
  pipe_reg #(
    .T       (idex_t),
    .RST_VAL (c_idexBubble),
    .CLR_VAL (c_idexBubble)
  ) u_idex (
    .clk   (clk),
    .rst   (rst),
    .i_en  (1'b1),
    .i_clr (bus.FlushE),
    .i_d   (w_idexD),
    .o_q   (w_idexQ)
  );

  // A bubble enters execute either from an explicit flush or a flushed decode slot.
  assign w_bubbleLoad = bus.FlushE | ~w_ifidQ.valid;

  // Saturating bubble counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                                     r_bubbleCnt <= '0;
    else if (w_bubbleLoad && (r_bubbleCnt != '1)) r_bubbleCnt <= r_bubbleCnt + 16'd1;
  end

  assign bus.PCF       = r_pcF;
  assign bus.InstrD    = w_ifidQ.instr;
  assign bus.PCD       = w_ifidQ.pc;
  assign bus.PCPlus4D  = w_ifidQ.pcPlus4;
  assign bus.CtrlE     = w_idexQ.ctrl;
  assign bus.RD1E      = w_idexQ.rd1;
  assign bus.RD2E      = w_idexQ.rd2;
  assign bus.ImmExtE   = w_idexQ.imm;
  assign bus.PCE       = w_idexQ.pc;
  assign bus.PCPlus4E  = w_idexQ.pcPlus4;
  assign bus.Rs1E      = w_idexQ.rs1;
  assign bus.Rs2E      = w_idexQ.rs2;
  assign bus.RdE       = w_idexQ.rd;
  assign bus.ValidE    = w_idexQ.valid;
  assign bus.BubbleCnt = r_bubbleCnt;

endmodule
`default_nettype wire
